// File: rtl/riscv_pma_pkg.sv
// rtl/riscv_pma_pkg.sv - PMA attribute types, register-bus selectors and commit FSM states
package riscv_pma_pkg;

  typedef enum logic [1:0] {
    MEM_TYPE_EMPTY = 2'd0,
    MEM_TYPE_MAIN  = 2'd1,
    MEM_TYPE_IO    = 2'd2,
    MEM_TYPE_TCM   = 2'd3
  } mem_type_t;

  typedef enum logic [1:0] {
    AMO_TYPE_NONE       = 2'd0,
    AMO_TYPE_SWAP       = 2'd1,
    AMO_TYPE_LOGICAL    = 2'd2,
    AMO_TYPE_ARITHMETIC = 2'd3
  } amo_type_t;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    TOR   = 2'd1,
    NA4   = 2'd2,
    NAPOT = 2'd3
  } pma_a_t;

  typedef struct packed {
    mem_type_t mem_type;
    logic      r;
    logic      w;
    logic      x;
    logic      c;
    logic      cc;
    amo_type_t amo_type;
    pma_a_t    a;
  } pmacfg_t;

  localparam int PMACFG_BITS = $bits(pmacfg_t);

  localparam logic [1:0] PMA_REG_SEL_CFG  = 2'b00;
  localparam logic [1:0] PMA_REG_SEL_ADR  = 2'b01;
  localparam logic [1:0] PMA_REG_SEL_LOCK = 2'b10;

  localparam pmacfg_t PMACFG_RESET = '{
    mem_type: MEM_TYPE_EMPTY, r: 1'b0, w: 1'b0, x: 1'b0, c: 1'b0, cc: 1'b0,
    amo_type: AMO_TYPE_NONE, a: OFF
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    COMMIT = 2'd2
  } pma_commit_state_t;

endpackage

// File: rtl/riscv_pmacfg_regs.sv
// rtl/riscv_pmacfg_regs.sv - PMA shadow/active config store with drained atomic commit
// RV_PMA_LOCK_EN adds sticky per-entry locks (sel=10); without it sel=10 always errors.
module riscv_pmacfg_regs
  import riscv_pma_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int PMA_CNT  = 16,
  parameter int IDX_BITS = (PMA_CNT > 1) ? $clog2(PMA_CNT) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          reg_req_i,
  input  logic                          reg_we_i,
  input  logic [1:0]                    reg_sel_i,
  input  logic [IDX_BITS-1:0]           reg_idx_i,
  input  logic [XLEN-1:0]               reg_wdata_i,
  output logic                          reg_ack_o,
  output logic                          reg_err_o,
  output logic [XLEN-1:0]               reg_rdata_o,
  input  logic                          commit_i,
  input  logic                          mem_busy_i,
  output logic                          commit_pending_o,
  output pmacfg_t [PMA_CNT-1:0]         pma_cfg_o,
  output logic [PMA_CNT-1:0][XLEN-1:0]  pma_adr_o
);

  pma_commit_state_t state_q, state_d;
  pmacfg_t           shadow_cfg [PMA_CNT];
  logic [XLEN-1:0]   shadow_adr [PMA_CNT];
  logic [PMA_CNT-1:0] lock, cfg_locked, adr_locked;
  logic              idx_ok, acc_err, wr_ok, do_commit;
  logic [XLEN-1:0]   rd_val;

  assign do_commit        = (state_q == COMMIT);
  assign commit_pending_o = (state_q != IDLE);
  assign wr_ok            = reg_req_i && reg_we_i && !acc_err;

  if (PMA_CNT == (1 << IDX_BITS)) begin : g_idx_full
    assign idx_ok = 1'b1;
  end else begin : g_idx_part
    localparam logic [IDX_BITS:0] CNT_W = PMA_CNT[IDX_BITS:0];
    assign idx_ok = ({1'b0, reg_idx_i} < CNT_W);
  end

  for (genvar i = 0; i < PMA_CNT; i++) begin : g_entry
    pmacfg_t         cfg_q, act_cfg_q;
    logic [XLEN-1:0] adr_q, act_adr_q;
    logic            hit;

    assign hit = wr_ok && (reg_idx_i == IDX_BITS'(i));

    // The copy reads the registered shadow, so a same-cycle write lands only on the next commit.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cfg_q     <= PMACFG_RESET;
        adr_q     <= '0;
        act_cfg_q <= PMACFG_RESET;
        act_adr_q <= '0;
      end else begin
        if (do_commit) begin
          act_cfg_q <= cfg_q;
          act_adr_q <= adr_q;
        end
        if (hit && reg_sel_i == PMA_REG_SEL_CFG) cfg_q <= pmacfg_t'(reg_wdata_i[PMACFG_BITS-1:0]);
        if (hit && reg_sel_i == PMA_REG_SEL_ADR) adr_q <= reg_wdata_i;
      end
    end

    assign shadow_cfg[i] = cfg_q;
    assign shadow_adr[i] = adr_q;
    assign pma_cfg_o[i]  = act_cfg_q;
    assign pma_adr_o[i]  = act_adr_q;

`ifdef RV_PMA_LOCK_EN
    logic lock_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                                                 lock_q <= 1'b0;
      else if (hit && reg_sel_i == PMA_REG_SEL_LOCK && reg_wdata_i[0]) lock_q <= 1'b1;
    end
    assign lock[i] = lock_q;
`else
    assign lock[i] = 1'b0;
`endif

    assign cfg_locked[i] = lock[i];
    // A locked TOR entry also freezes its lower bound held in the previous address.
    if (i + 1 < PMA_CNT) begin : g_tor
      assign adr_locked[i] = lock[i] || (lock[i+1] && shadow_cfg[i+1].a == TOR);
    end else begin : g_last
      assign adr_locked[i] = lock[i];
    end
  end

  always_comb begin
    acc_err = 1'b0;
    rd_val  = '0;
    case (reg_sel_i)
      PMA_REG_SEL_CFG: begin
        acc_err = reg_we_i && cfg_locked[reg_idx_i];
        rd_val  = XLEN'(shadow_cfg[reg_idx_i]);
      end
      PMA_REG_SEL_ADR: begin
        acc_err = reg_we_i && adr_locked[reg_idx_i];
        rd_val  = shadow_adr[reg_idx_i];
      end
`ifdef RV_PMA_LOCK_EN
      PMA_REG_SEL_LOCK: rd_val = XLEN'(lock[reg_idx_i]);
`endif
      default: acc_err = 1'b1;
    endcase
    if (!idx_ok) acc_err = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      reg_ack_o   <= 1'b0;
      reg_err_o   <= 1'b0;
      reg_rdata_o <= '0;
    end else begin
      reg_ack_o   <= reg_req_i;
      reg_err_o   <= reg_req_i && acc_err;
      reg_rdata_o <= (reg_req_i && !reg_we_i && !acc_err) ? rd_val : '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // commit_i outside IDLE folds into the commit already in flight.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (commit_i)    state_d = DRAIN;
      DRAIN:   if (!mem_busy_i) state_d = COMMIT;
      COMMIT:                   state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_riscv_pmacfg_regs.sv
// tb/tb_riscv_pmacfg_regs.sv - randomized bench for riscv_pmacfg_regs against a rule-level model
`timescale 1ns/1ps
module tb_riscv_pmacfg_regs;
  import riscv_pma_pkg::*;

  localparam int XLEN = 32, PMA_CNT = 16, IDX_BITS = 4;
`ifdef RV_PMA_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic reg_req = 0, reg_we = 0, commit = 0, mem_busy = 0;
  logic [1:0] reg_sel = '0;
  logic [IDX_BITS-1:0] reg_idx = '0;
  logic [XLEN-1:0] reg_wdata = '0, reg_rdata;
  logic reg_ack, reg_err, commit_pending;
  pmacfg_t [PMA_CNT-1:0] pma_cfg;
  logic [PMA_CNT-1:0][XLEN-1:0] pma_adr;
  logic [PMA_CNT-1:0][PMACFG_BITS-1:0] cfg_bits;
  assign cfg_bits = pma_cfg;

  riscv_pmacfg_regs #(.XLEN(XLEN), .PMA_CNT(PMA_CNT), .IDX_BITS(IDX_BITS)) dut (
    .clk_i(clk), .rst_i(rst), .reg_req_i(reg_req), .reg_we_i(reg_we), .reg_sel_i(reg_sel),
    .reg_idx_i(reg_idx), .reg_wdata_i(reg_wdata), .reg_ack_o(reg_ack), .reg_err_o(reg_err),
    .reg_rdata_o(reg_rdata), .commit_i(commit), .mem_busy_i(mem_busy),
    .commit_pending_o(commit_pending), .pma_cfg_o(pma_cfg), .pma_adr_o(pma_adr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  logic [PMACFG_BITS-1:0] m_cfg [PMA_CNT], m_cfg_act [PMA_CNT];
  logic [XLEN-1:0]        m_adr [PMA_CNT], m_adr_act [PMA_CNT];
  bit                     m_lock [PMA_CNT];

  function automatic void model_reset();
    pmacfg_t c;
    c = '0;
    c.mem_type = MEM_TYPE_EMPTY;
    c.a = OFF;
    for (int i = 0; i < PMA_CNT; i++) begin
      m_cfg[i] = c; m_cfg_act[i] = c; m_adr[i] = '0; m_adr_act[i] = '0; m_lock[i] = 1'b0;
    end
  endfunction

  function automatic void model_commit();
    for (int i = 0; i < PMA_CNT; i++) begin
      m_cfg_act[i] = m_cfg[i];
      m_adr_act[i] = m_adr[i];
    end
  endfunction

  function automatic bit tor_guard(int k);
    pmacfg_t c;
    if (k + 1 >= PMA_CNT) return 1'b0;
    c = pmacfg_t'(m_cfg[k+1]);
    return m_lock[k+1] && (c.a == TOR);
  endfunction

  function automatic void model_access(input bit we, input logic [1:0] sel, input int idx,
                                       input logic [XLEN-1:0] wd, output bit e_err,
                                       output logic [XLEN-1:0] e_rd);
    e_err = 1'b0;
    e_rd  = '0;
    if (idx >= PMA_CNT || sel == 2'b11 || (sel == 2'b10 && !LOCK_EN)) e_err = 1'b1;
    else if (we && sel == 2'b00 && m_lock[idx]) e_err = 1'b1;
    else if (we && sel == 2'b01 && (m_lock[idx] || tor_guard(idx))) e_err = 1'b1;
    if (e_err) return;
    if (we) begin
      if (sel == 2'b00) m_cfg[idx] = wd[PMACFG_BITS-1:0];
      if (sel == 2'b01) m_adr[idx] = wd;
      if (sel == 2'b10 && wd[0]) m_lock[idx] = 1'b1;
    end else begin
      if (sel == 2'b00) e_rd = XLEN'(m_cfg[idx]);
      if (sel == 2'b01) e_rd = m_adr[idx];
      if (sel == 2'b10) e_rd = XLEN'(m_lock[idx]);
    end
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic access(input bit we, input logic [1:0] sel, input int idx, input logic [XLEN-1:0] wd,
                        output logic ack, output logic err, output logic [XLEN-1:0] rd);
    reg_req = 1'b1; reg_we = we; reg_sel = sel; reg_idx = idx[IDX_BITS-1:0]; reg_wdata = wd;
    @(posedge clk);
    #1;
    reg_req = 1'b0; reg_we = 1'b0;
    ack = reg_ack; err = reg_err; rd = reg_rdata;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    @(posedge clk);
    #1;
    commit = 1'b0;
  endtask

  task automatic test_reset();
    logic ack, err; logic [XLEN-1:0] rd, e_rd; bit e_err; pmacfg_t c; int bad;
    #12;
    n_cmp++;
    if (reg_ack !== 1'b0 || reg_err !== 1'b0 || reg_rdata !== '0 || commit_pending !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_resp: ack=%b err=%b rdata=%h pend=%b want 0/0/0/0", reg_ack, reg_err, reg_rdata, commit_pending);
    end
    bad = 0;
    for (int i = 0; i < PMA_CNT; i++)
      if (cfg_bits[i] !== m_cfg_act[i] || pma_cfg[i].a !== OFF || pma_adr[i] !== '0) bad++;
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL reset_active: %0d entries not reset, want 0", bad); end
    @(posedge clk); #1; rst = 1'b0;
    access(1'b0, PMA_REG_SEL_CFG, 3, '0, ack, err, rd);
    model_access(1'b0, PMA_REG_SEL_CFG, 3, '0, e_err, e_rd);
    c = pmacfg_t'(rd[PMACFG_BITS-1:0]);
    n_cmp++;
    if (ack !== 1'b1 || err !== e_err || rd !== e_rd || c.mem_type !== MEM_TYPE_EMPTY || c.a !== OFF) begin
      n_bad++;
      $display("FAIL reset_read_cfg3: ack=%b err=%b rdata=%h want 1/%b/%h", ack, err, rd, e_err, e_rd);
    end
    cycles(1);
    n_cmp++;
    if (reg_ack !== 1'b0) begin n_bad++; $display("FAIL ack_single_pulse: ack=%b want 0", reg_ack); end
  endtask

  task automatic test_commit_basic();
    logic ack, err; logic [XLEN-1:0] rd, e_rd; bit e_err; pmacfg_t c; int pend_cycles, bad;
    access(1'b1, PMA_REG_SEL_ADR, 2, 32'h2000_01FF, ack, err, rd);
    model_access(1'b1, PMA_REG_SEL_ADR, 2, 32'h2000_01FF, e_err, e_rd);
    c = '0; c.mem_type = MEM_TYPE_MAIN; c.r = 1'b1; c.w = 1'b1; c.x = 1'b1; c.a = NAPOT;
    access(1'b1, PMA_REG_SEL_CFG, 2, XLEN'(c), ack, err, rd);
    model_access(1'b1, PMA_REG_SEL_CFG, 2, XLEN'(c), e_err, e_rd);
    n_cmp++;
    if (ack !== 1'b1 || err !== 1'b0 || pma_adr[2] !== 32'h0) begin
      n_bad++;
      $display("FAIL shadow_only_write: ack=%b err=%b active_adr2=%h want 1/0/0", ack, err, pma_adr[2]);
    end
    mem_busy = 1'b0;
    pend_cycles = 0;
    pulse_commit();
    for (int k = 0; k < 2; k++) begin
      if (commit_pending === 1'b1) pend_cycles++;
      n_cmp++;
      if (pma_adr[2] !== 32'h0) begin
        n_bad++;
        $display("FAIL early_apply_cycle%0d: active_adr2=%h want 0", k, pma_adr[2]);
      end
      cycles(1);
    end
    if (commit_pending === 1'b1) pend_cycles++;
    n_cmp++;
    if (pma_adr[2] !== 32'h2000_01FF || pma_cfg[2] !== c || pend_cycles != 2) begin
      n_bad++;
      $display("FAIL commit_apply: adr2=%h cfg2=%h pend_cycles=%0d want 200001ff/%h/2", pma_adr[2], pma_cfg[2], pend_cycles, c);
    end
    model_commit();
    bad = 0;
    for (int i = 0; i < PMA_CNT; i++)
      if (cfg_bits[i] !== m_cfg_act[i] || pma_adr[i] !== m_adr_act[i]) bad++;
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL commit_all_entries: %0d entries differ, want 0", bad); end
  endtask

  task automatic test_drain();
    logic ack, err; logic [XLEN-1:0] rd, e_rd, old0, pre1; bit e_err;
    old0 = m_adr_act[0];
    mem_busy = 1'b1;
    pulse_commit();
    access(1'b1, PMA_REG_SEL_ADR, 0, 32'h10, ack, err, rd);
    model_access(1'b1, PMA_REG_SEL_ADR, 0, 32'h10, e_err, e_rd);
    n_cmp++;
    if (ack !== 1'b1 || err !== e_err) begin
      n_bad++; $display("FAIL drain_write: ack=%b err=%b want 1/%b", ack, err, e_err);
    end
    pulse_commit();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (commit_pending !== 1'b1 || pma_adr[0] !== old0) begin
        n_bad++;
        $display("FAIL drain_hold%0d: pend=%b adr0=%h want 1/%h", k, commit_pending, pma_adr[0], old0);
      end
      cycles(1);
    end
    mem_busy = 1'b0;
    cycles(1);
    n_cmp++;
    if (commit_pending !== 1'b1 || pma_adr[0] !== old0) begin
      n_bad++; $display("FAIL commit_cycle: pend=%b adr0=%h want 1/%h", commit_pending, pma_adr[0], old0);
    end
    pre1 = m_adr[1];
    model_commit();
    access(1'b1, PMA_REG_SEL_ADR, 1, 32'h55, ack, err, rd);
    model_access(1'b1, PMA_REG_SEL_ADR, 1, 32'h55, e_err, e_rd);
    n_cmp++;
    if (ack !== 1'b1 || pma_adr[0] !== 32'h10 || pma_adr[1] !== pre1 || commit_pending !== 1'b0) begin
      n_bad++;
      $display("FAIL write_during_commit: adr0=%h adr1=%h pend=%b want 10/%h/0", pma_adr[0], pma_adr[1], commit_pending, pre1);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (commit_pending !== 1'b0 || pma_adr[1] !== pre1) begin
        n_bad++; $display("FAIL no_extra_commit%0d: pend=%b adr1=%h want 0/%h", k, commit_pending, pma_adr[1], pre1);
      end
      cycles(1);
    end
    pulse_commit();
    cycles(2);
    model_commit();
    n_cmp++;
    if (pma_adr[1] !== 32'h55) begin n_bad++; $display("FAIL later_commit_adr1: %h want 55", pma_adr[1]); end
  endtask

  task automatic test_errors();
    logic ack, err; logic [XLEN-1:0] rd, e_rd, wd; bit e_err;
    wd = $urandom;
    access(1'b1, PMA_REG_SEL_CFG, 15, wd, ack, err, rd);
    model_access(1'b1, PMA_REG_SEL_CFG, 15, wd, e_err, e_rd);
    n_cmp++;
    if (ack !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL write_idx15: ack=%b err=%b want 1/0", ack, err); end
    access(1'b1, 2'b11, 15, ~wd, ack, err, rd);
    model_access(1'b1, 2'b11, 15, ~wd, e_err, e_rd);
    n_cmp++;
    if (ack !== 1'b1 || err !== 1'b1 || rd !== '0) begin
      n_bad++; $display("FAIL sel11_write: ack=%b err=%b rdata=%h want 1/1/0", ack, err, rd);
    end
    access(1'b0, 2'b11, 4, '0, ack, err, rd);
    n_cmp++;
    if (err !== 1'b1 || rd !== '0) begin n_bad++; $display("FAIL sel11_read: err=%b rdata=%h want 1/0", err, rd); end
    access(1'b0, PMA_REG_SEL_CFG, 15, '0, ack, err, rd);
    model_access(1'b0, PMA_REG_SEL_CFG, 15, '0, e_err, e_rd);
    n_cmp++;
    if (err !== 1'b0 || rd !== XLEN'(wd[PMACFG_BITS-1:0])) begin
      n_bad++; $display("FAIL cfg15_readback: err=%b rdata=%h want 0/%h", err, rd, XLEN'(wd[PMACFG_BITS-1:0]));
    end
    access(1'b0, PMA_REG_SEL_LOCK, 9, '0, ack, err, rd);
    model_access(1'b0, PMA_REG_SEL_LOCK, 9, '0, e_err, e_rd);
    n_cmp++;
    if (err !== e_err || rd !== e_rd) begin
      n_bad++; $display("FAIL lock_sel_read: err=%b rdata=%h want %b/%h", err, rd, e_err, e_rd);
    end
  endtask

  task automatic test_lock();
    logic ack, err; logic [XLEN-1:0] rd, e_rd; bit e_err; pmacfg_t c;
    c = '0; c.mem_type = MEM_TYPE_MAIN; c.r = 1'b1; c.a = TOR;
    access(1'b1, PMA_REG_SEL_CFG, 5, XLEN'(c), ack, err, rd);
    model_access(1'b1, PMA_REG_SEL_CFG, 5, XLEN'(c), e_err, e_rd);
    access(1'b1, PMA_REG_SEL_LOCK, 5, 32'h1, ack, err, rd);
    model_access(1'b1, PMA_REG_SEL_LOCK, 5, 32'h1, e_err, e_rd);
`ifdef RV_PMA_LOCK_EN
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL lock_set: err=%b want 0", err); end
    access(1'b1, PMA_REG_SEL_ADR, 4, 32'hABCD, ack, err, rd);
    model_access(1'b1, PMA_REG_SEL_ADR, 4, 32'hABCD, e_err, e_rd);
    n_cmp++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL tor_lower_locked: err=%b want 1", err); end
    access(1'b1, PMA_REG_SEL_ADR, 5, 32'hABCD, ack, err, rd);
    model_access(1'b1, PMA_REG_SEL_ADR, 5, 32'hABCD, e_err, e_rd);
    n_cmp++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL adr5_locked: err=%b want 1", err); end
    access(1'b1, PMA_REG_SEL_CFG, 5, '0, ack, err, rd);
    model_access(1'b1, PMA_REG_SEL_CFG, 5, '0, e_err, e_rd);
    n_cmp++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL cfg5_locked: err=%b want 1", err); end
    access(1'b1, PMA_REG_SEL_ADR, 6, 32'h6666, ack, err, rd);
    model_access(1'b1, PMA_REG_SEL_ADR, 6, 32'h6666, e_err, e_rd);
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL adr6_open: err=%b want 0", err); end
    access(1'b1, PMA_REG_SEL_LOCK, 5, 32'h0, ack, err, rd);
    model_access(1'b1, PMA_REG_SEL_LOCK, 5, 32'h0, e_err, e_rd);
    access(1'b0, PMA_REG_SEL_LOCK, 5, '0, ack, err, rd);
    n_cmp++;
    if (err !== 1'b0 || rd !== 32'h1) begin n_bad++; $display("FAIL lock_sticky: err=%b rdata=%h want 0/1", err, rd); end
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    model_reset();
    access(1'b1, PMA_REG_SEL_ADR, 4, 32'h4444, ack, err, rd);
    model_access(1'b1, PMA_REG_SEL_ADR, 4, 32'h4444, e_err, e_rd);
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL lock_cleared_by_reset: err=%b want 0", err); end
`else
    n_cmp++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL lock_absent_write: err=%b want 1", err); end
    access(1'b1, PMA_REG_SEL_ADR, 4, 32'hABCD, ack, err, rd);
    model_access(1'b1, PMA_REG_SEL_ADR, 4, 32'hABCD, e_err, e_rd);
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL adr4_unlocked: err=%b want 0", err); end
`endif
  endtask

  task automatic test_random();
    logic ack, err; logic [XLEN-1:0] rd, e_rd, wd; bit e_err, we; logic [1:0] sel;
    int idx, r, nbusy, bad, acc_bad;
    for (int round = 0; round < 3; round++) begin
      acc_bad = 0;
      for (int n = 0; n < 100; n++) begin
        we = 1'($urandom_range(0, 1));
        r = $urandom_range(0, 9);
        sel = (r < 4) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
        idx = $urandom_range(0, PMA_CNT - 1);
        wd = $urandom;
        access(we, sel, idx, wd, ack, err, rd);
        model_access(we, sel, idx, wd, e_err, e_rd);
        n_cmp++;
        if (ack !== 1'b1 || err !== e_err || (!we && rd !== e_rd)) begin
          n_bad++; acc_bad++;
          if (acc_bad < 5)
            $display("FAIL rand_access: we=%b sel=%b idx=%0d ack=%b err=%b rdata=%h want 1/%b/%h", we, sel, idx, ack, err, rd, e_err, e_rd);
        end
      end
      nbusy = $urandom_range(0, 4);
      mem_busy = (nbusy > 0);
      pulse_commit();
      for (int k = 0; k < nbusy; k++) begin
        bad = 0;
        for (int i = 0; i < PMA_CNT; i++)
          if (cfg_bits[i] !== m_cfg_act[i] || pma_adr[i] !== m_adr_act[i]) bad++;
        n_cmp++;
        if (bad != 0 || commit_pending !== 1'b1) begin
          n_bad++; $display("FAIL rand_drain_hold: %0d entries changed pend=%b want 0/1", bad, commit_pending);
        end
        cycles(1);
      end
      mem_busy = 1'b0;
      cycles(2);
      model_commit();
      bad = 0;
      for (int i = 0; i < PMA_CNT; i++)
        if (cfg_bits[i] !== m_cfg_act[i] || pma_adr[i] !== m_adr_act[i]) bad++;
      n_cmp++;
      if (bad != 0 || commit_pending !== 1'b0) begin
        n_bad++; $display("FAIL rand_commit: %0d entries differ pend=%b want 0/0", bad, commit_pending);
      end
    end
  endtask

  task automatic test_reset_in_drain();
    logic ack, err; logic [XLEN-1:0] rd, e_rd, wd; bit e_err; int bad;
    rst = 1'b1; cycles(1); rst = 1'b0;
    model_reset();
    wd = $urandom | 32'h1;
    access(1'b1, PMA_REG_SEL_ADR, 7, wd, ack, err, rd);
    model_access(1'b1, PMA_REG_SEL_ADR, 7, wd, e_err, e_rd);
    pulse_commit();
    cycles(2);
    model_commit();
    access(1'b1, PMA_REG_SEL_ADR, 7, ~wd, ack, err, rd);
    model_access(1'b1, PMA_REG_SEL_ADR, 7, ~wd, e_err, e_rd);
    mem_busy = 1'b1;
    pulse_commit();
    cycles(1);
    n_cmp++;
    if (commit_pending !== 1'b1 || pma_adr[7] !== wd) begin
      n_bad++; $display("FAIL pre_reset_state: pend=%b adr7=%h want 1/%h", commit_pending, pma_adr[7], wd);
    end
    rst = 1'b1;
    #2;
    model_reset();
    bad = 0;
    for (int i = 0; i < PMA_CNT; i++)
      if (cfg_bits[i] !== m_cfg_act[i] || pma_adr[i] !== '0) bad++;
    n_cmp++;
    if (bad != 0 || commit_pending !== 1'b0 || reg_ack !== 1'b0) begin
      n_bad++; $display("FAIL async_reset_drain: %0d entries pend=%b ack=%b want 0/0/0", bad, commit_pending, reg_ack);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    mem_busy = 1'b0;
    access(1'b1, PMA_REG_SEL_ADR, 3, 32'h3333, ack, err, rd);
    model_access(1'b1, PMA_REG_SEL_ADR, 3, 32'h3333, e_err, e_rd);
    cycles(4);
    bad = 0;
    for (int i = 0; i < PMA_CNT; i++)
      if (cfg_bits[i] !== m_cfg_act[i] || pma_adr[i] !== m_adr_act[i]) bad++;
    n_cmp++;
    if (bad != 0 || commit_pending !== 1'b0) begin
      n_bad++; $display("FAIL no_commit_after_reset: %0d entries pend=%b want 0/0", bad, commit_pending);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_commit_basic();
    test_drain();
    test_errors();
    test_lock();
    test_random();
    test_reset_in_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv_pmacfg_regs.md
Name: riscv_pmacfg_regs

Overview:
- Programmable store of the Physical Memory Attribute configuration: the writer side of the per-entry pmacfg_t/address arrays consumed by the PMA checkers (instruction and data side).
- Software writes a shadow copy over a simple register-bus handshake.
- A commit sequence waits for in-flight memory accesses to drain, then copies shadow to active atomically, so checkers never see a half-programmed region set.

Parameters:
- XLEN, 32, register data width and width of each PMA address entry.
- PMA_CNT, 16, number of PMA entries (1..16).
- IDX_BITS, $clog2(PMA_CNT) (min 1), width of the entry index.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- reg_req_i  in  1  register access request (single-cycle pulse)
- reg_we_i  in  1  1=write, 0=read
- reg_sel_i  in  2  00=cfg, 01=adr, 10=lock, 11=reserved
- reg_idx_i  in  IDX_BITS  entry index
- reg_wdata_i  in  XLEN  write data; cfg uses low PMACFG_BITS bits
- reg_ack_o  out  1  access complete, one cycle after reg_req_i
- reg_err_o  out  1  access rejected; valid with reg_ack_o
- reg_rdata_o  out  XLEN  read data, zero-extended; valid with reg_ack_o
- commit_i  in  1  request shadow→active copy (pulse)
- mem_busy_i  in  1  a checked memory access is outstanding
- commit_pending_o  out  1  commit requested, not yet applied
- pma_cfg_o  out  pmacfg_t[PMA_CNT]  active configuration to the checkers
- pma_adr_o  out  XLEN[PMA_CNT]  active addresses to the checkers

Behaviour:
- Reset (async, immediate): all shadow/active cfg = {mem_type=MEM_TYPE_EMPTY, a=OFF, all other fields 0}. All adr = 0. Locks = 0. reg_ack_o/reg_err_o/reg_rdata_o = 0. commit_pending_o = 0. State IDLE. Reset during DRAIN/COMMIT discards the commit.
- Register access: sampled when reg_req_i=1. reg_ack_o pulses exactly 1 cycle later, regardless of commit state.
- Writes update only the shadow. Reads return the shadow value. Write data is registered on the request cycle.
- Errors (reg_err_o=1, no state change, rdata=0):
  - reg_idx_i >= PMA_CNT
  - reg_sel_i=11
  - reg_sel_i=10 when the lock feature is absent
  - a write to a locked target
- State machine:
  - IDLE: commit_i → DRAIN, commit_pending_o=1.
  - DRAIN: stay while mem_busy_i=1. mem_busy_i=0 → COMMIT. Writes accepted in DRAIN are included in the commit.
  - COMMIT (1 cycle): active ← shadow for all entries; next state IDLE; commit_pending_o falls the following cycle.
  - Overall latency: commit_i to active update ≥ 2 cycles (IDLE→DRAIN→COMMIT, the copy taking effect at the end of the COMMIT cycle).
- commit_i while not IDLE: ignored, since it is merged into the current commit.
- Shadow write and COMMIT copy in the same cycle: active receives the pre-write shadow; the new value waits for the next commit.
- pma_cfg_o/pma_adr_o are direct register outputs; they change only in the COMMIT cycle or on reset.

Optional Feature:
- Macro: RV_PMA_LOCK_EN.
- Defined:
  - Per-entry lock bit, written via sel=10 with wdata[0]; write-1 sets, write-0 has no effect.
  - Only reset clears a lock.
  - Lock read returns {0, lock[i]}.
  - Locked entry i: writes to cfg[i]/adr[i] error.
  - If shadow cfg[i].a==TOR, adr[i-1] is also locked, for i>0.
  - Setting a lock takes effect immediately on the shadow and does not require a commit.
- Undefined: no lock storage; sel=10 always errors; all in-range cfg/adr writes succeed.

Decomposition:
- riscv_pma_pkg (existing): pmacfg_t, mem_type/amo_type/a encodings.
- New in riscv_pma_pkg:
  - PMACFG_BITS = $bits(pmacfg_t).
  - PMA_REG_SEL_CFG/ADR/LOCK constants.
  - pma_commit_state_t enum {IDLE, DRAIN, COMMIT}.
- No sub-module. The per-entry shadow/active/lock storage is a generate loop; the commit FSM stays in this module.

Test Plan:
1. Reset, then read cfg[3] → ack after 1 cycle, err=0, rdata decodes to mem_type=MEM_TYPE_EMPTY, a=OFF. pma_cfg_o[*].a=OFF.
2. Write adr[2]=0x2000_01FF, then cfg[2] to NAPOT/MAIN/rwx. pma_adr_o[2] stays 0 until commit_i with mem_busy_i=0. pma_adr_o[2]=0x2000_01FF at the end of the COMMIT cycle (2 cycles after commit_i). commit_pending_o high for exactly 2 cycles.
3. commit_i with mem_busy_i held high for 5 cycles; write adr[0]=0x10 during DRAIN → active unchanged for 5 cycles, then adr[0]=0x10 applied. A second commit_i during DRAIN causes no extra commit.
4. PMA_CNT=16, write cfg with reg_idx_i=15 → ok. Write with reg_sel_i=11 → err=1, shadow unchanged, rdata=0.
5. RV_PMA_LOCK_EN: set cfg[5].a=TOR, write lock[5]=1. Write adr[4] → err=1. Write adr[5] → err=1. Write adr[6] → ok. Assert rst_i → lock cleared, write adr[4] → ok.
6. Assert rst_i in the DRAIN state → outputs return to reset values immediately, commit_pending_o=0. After release, the shadow contents are not applied without a new commit_i.
